// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//
// Serialises a latched bit pattern MSB-first (pattern[len-1] .. pattern[0]),
// repeating it `reps` times with GAP idle cycles between repetitions. A
// `reps` value of 0 repeats until `stop` is asserted. All outputs are
// registered, and the first bit appears in the cycle right after the edge
// that samples `start`.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (2..32)
//   GAP      idle cycles between repetitions (0..15)
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous, active-high reset
//   start    begin transmission (sampled in IDLE only)
//   stop     synchronous abort (sampled in every state, wins over start)
//   pattern  bit pattern, bit len-1 sent first
//   len      number of pattern bits to send (1..MAX_LEN accepted)
//   reps     repetition count, 0 = repeat until stop
//   w        serial data
//   valid    w carries a pattern bit
//   busy     high in SEND and GAP
//   done     one-cycle pulse after the last bit of the last repetition
// ---------------------------------------------------------------------------
module sequence_generator #(
    parameter int MAX_LEN = 16,
    parameter int GAP     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic [MAX_LEN-1:0]           pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] len,
    input  logic [3:0]                   reps,
    output logic                         w,
    output logic                         valid,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_GAP  = 2'b10
    } state_t;

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;     // index of the bit currently on w
    logic [3:0]         rep_q, rep_n;     // completed repetitions
    logic [3:0]         gap_q, gap_n;     // gap cycles already spent
    logic [MAX_LEN-1:0] pat_q, pat_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [3:0]         reps_q, reps_n;
    logic               w_n, valid_n, busy_n, done_n;

    logic               len_ok;
    logic [IDX_W-1:0]   in_top;           // len-1 of the incoming request
    logic [IDX_W-1:0]   lat_top;          // len-1 of the latched request
    logic               last_rep;

    assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
    assign in_top   = IDX_W'(len - LEN_W'(1));
    assign lat_top  = IDX_W'(len_q - LEN_W'(1));
    assign last_rep = (reps_q != 4'd0) && ((rep_q + 4'd1) == reps_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_n = state_q;
        idx_n   = idx_q;
        rep_n   = rep_q;
        gap_n   = gap_q;
        pat_n   = pat_q;
        len_n   = len_q;
        reps_n  = reps_q;
        w_n     = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!stop && start && len_ok) begin
                    state_n = S_SEND;
                    pat_n   = pattern;
                    len_n   = len;
                    reps_n  = reps;
                    idx_n   = in_top;
                    rep_n   = 4'd0;
                    gap_n   = 4'd0;
                    w_n     = pattern[in_top];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end

            S_SEND: begin
                if (stop) begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    rep_n   = 4'd0;
                    gap_n   = 4'd0;
                end else if (idx_q != '0) begin
                    idx_n   = idx_q - IDX_W'(1);
                    w_n     = pat_q[idx_q - IDX_W'(1)];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (last_rep) begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    rep_n   = 4'd0;
                    done_n  = 1'b1;
                end else begin
                    // Endless mode never counts, so the counter cannot wrap.
                    if (reps_q != 4'd0) rep_n = rep_q + 4'd1;
                    busy_n = 1'b1;
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        gap_n   = 4'd0;
                    end else begin
                        idx_n   = lat_top;
                        w_n     = pat_q[lat_top];
                        valid_n = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    rep_n   = 4'd0;
                    gap_n   = 4'd0;
                end else if (gap_q == GAP_LAST) begin
                    state_n = S_SEND;
                    gap_n   = 4'd0;
                    idx_n   = lat_top;
                    w_n     = pat_q[lat_top];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    gap_n  = gap_q + 4'd1;
                    busy_n = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                rep_n   = 4'd0;
                gap_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched request registers are reset too, so nothing from an aborted transfer survives reset.
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= 4'd0;
            gap_q   <= 4'd0;
            pat_q   <= '0;
            len_q   <= '0;
            reps_q  <= 4'd0;
            w       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q <= state_n;
            idx_q   <= idx_n;
            rep_q   <= rep_n;
            gap_q   <= gap_n;
            pat_q   <= pat_n;
            len_q   <= len_n;
            reps_q  <= reps_n;
            w       <= w_n;
            valid   <= valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
//
// Drives one GAP=2 and one GAP=0 instance with the same inputs. Expected
// per-cycle {w, valid, busy, done} vectors are generated from the stimulus
// into one queue per instance; an empty queue means "idle" (all zeros).
// ---------------------------------------------------------------------------
module tb_sequence_generator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;

    logic w2, valid2, busy2, done2;
    logic w0, valid0, busy0, done0;

    sequence_generator #(.MAX_LEN(16), .GAP(2)) dut_gap2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pattern(pattern), .len(len), .reps(reps),
        .w(w2), .valid(valid2), .busy(busy2), .done(done2)
    );

    sequence_generator #(.MAX_LEN(16), .GAP(0)) dut_gap0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pattern(pattern), .len(len), .reps(reps),
        .w(w0), .valid(valid0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [3:0] q2[$];
    logic [3:0] q0[$];

    task automatic push(input int which, input logic [3:0] v);
        if (which == 2) q2.push_back(v);
        else            q0.push_back(v);
    endtask

    // Reference model of one request: bits MSB-first, GAP idles between
    // repetitions, a done cycle at the end. Endless mode is cut at `limit`.
    task automatic push_txn(input int which, input logic [15:0] pat,
                            input int ln, input int rp, input int gap,
                            input int limit);
        int n;
        n = 0;
        for (int r = 0; (rp == 0) || (r < rp); r++) begin
            for (int i = ln - 1; i >= 0; i--) begin
                if (rp == 0 && n >= limit) return;
                push(which, {pat[i], 3'b110});
                n++;
            end
            if (rp == 0 || r < rp - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (rp == 0 && n >= limit) return;
                    push(which, 4'b0010);
                    n++;
                end
            end
        end
        push(which, 4'b0001);
    endtask

    task automatic push_both(input logic [15:0] pat, input int ln,
                             input int rp, input int limit);
        push_txn(2, pat, ln, rp, 2, limit);
        push_txn(0, pat, ln, rp, 0, limit);
    endtask

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got {w,valid,busy,done}=%b expected %b", tag, got, exp);
    endtask

    // One clock: sample #1 after the edge and compare both instances.
    task automatic step(input string tag);
        logic [3:0] e2, e0;
        @(posedge clk);
        #1;
        e2 = (q2.size() != 0) ? q2.pop_front() : 4'b0000;
        e0 = (q0.size() != 0) ? q0.pop_front() : 4'b0000;
        check({tag, "/gap2"}, {w2, valid2, busy2, done2}, e2);
        check({tag, "/gap0"}, {w0, valid0, busy0, done0}, e0);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((q2.size() != 0 || q0.size() != 0) && guard < 200) begin
            step(tag);
            guard++;
        end
        step({tag, "_idle"});
    endtask

    task automatic pulse_start(input logic [15:0] pat, input int ln,
                               input int rp, input string tag);
        pattern = pat;
        len     = 5'(ln);
        reps    = 4'(rp);
        start   = 1'b1;
        step(tag);
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        pattern = '0; len = '0; reps = '0;
        #12;
        check("reset_outputs/gap2", {w2, valid2, busy2, done2}, 4'b0000);
        check("reset_outputs/gap0", {w0, valid0, busy0, done0}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        step("idle_after_reset");

        // 0xB, len 4, single repetition
        push_both(16'h000B, 4, 1, 0);
        pulse_start(16'h000B, 4, 1, "b_len4");
        drain("b_len4");

        // 0x6, len 3, two repetitions (gap between them on the GAP=2 part)
        push_both(16'h0006, 3, 2, 0);
        pulse_start(16'h0006, 3, 2, "six_len3");
        drain("six_len3");

        // 0x3, len 2, three repetitions: GAP=0 part streams six ones
        push_both(16'h0003, 2, 3, 0);
        pulse_start(16'h0003, 2, 3, "three_len2");
        drain("three_len2");

        // Rejected requests: len=0, len>MAX_LEN, start together with stop
        pulse_start(16'hFFFF, 0, 1, "len_zero");
        step("len_zero_hold");
        pulse_start(16'hFFFF, 17, 1, "len_17");
        step("len_17_hold");
        stop = 1'b1;
        pulse_start(16'hFFFF, 4, 1, "start_stop");
        stop = 1'b0;
        step("start_stop_hold");

        // Boundary lengths: len=MAX_LEN and len=1
        push_both(16'h8001, 16, 1, 0);
        pulse_start(16'h8001, 16, 1, "len_max");
        drain("len_max");
        push_both(16'h0001, 1, 2, 0);
        pulse_start(16'h0001, 1, 2, "len_one");
        drain("len_one");

        // Inputs changing and start re-asserted while busy have no effect
        push_both(16'h00A5, 8, 1, 0);
        pulse_start(16'h00A5, 8, 1, "busy_ignore");
        step("busy_ignore");
        pattern = 16'hFFFF; len = 5'd3; reps = 4'd5; start = 1'b1;
        step("busy_ignore");
        step("busy_ignore");
        step("busy_ignore");
        start = 1'b0;
        drain("busy_ignore");

        // Start sampled in the done cycle is accepted immediately
        push_both(16'h0002, 2, 1, 0);
        push_both(16'h0005, 3, 1, 0);
        pulse_start(16'h0002, 2, 1, "b2b_first");
        step("b2b_first");
        step("b2b_done");
        pulse_start(16'h0005, 3, 1, "b2b_second");
        drain("b2b_second");

        // Endless mode, stop after seven output cycles; done never appears
        push_both(16'h0009, 4, 0, 7);
        pulse_start(16'h0009, 4, 0, "endless");
        for (int i = 0; i < 6; i++) step("endless");
        stop = 1'b1;
        step("endless_stop");
        stop = 1'b0;
        step("endless_idle");
        step("endless_idle");

        // Asynchronous reset in the middle of a len=8 transfer
        push_both(16'h00C3, 8, 1, 0);
        pulse_start(16'h00C3, 8, 1, "async_rst");
        step("async_rst");
        step("async_rst");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_now/gap2", {w2, valid2, busy2, done2}, 4'b0000);
        check("async_rst_now/gap0", {w0, valid0, busy0, done0}, 4'b0000);
        q2.delete();
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_idle");
        push_both(16'h005A, 8, 2, 0);
        pulse_start(16'h005A, 8, 2, "post_rst");
        drain("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter: MAX_LEN, default 16, maximum pattern length in bits (2..32).
REQ-002 Parameter: GAP, default 2, number of idle cycles (w=0, valid=0) between repetitions (0..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin transmission, sampled in IDLE only.
REQ-006 stop  input  1  synchronous abort request, sampled in any state.
REQ-007 pattern  input  MAX_LEN  bit pattern; bit len-1 is sent first.
REQ-008 len  input  clog2(MAX_LEN+1)  number of pattern bits to send.
REQ-009 reps  input  4  repetition count; 0 means repeat until stop.
REQ-010 w  output  1  serial data, registered.
REQ-011 valid  output  1  w carries a pattern bit this cycle, registered.
REQ-012 busy  output  1  high in SEND and GAP states, registered.
REQ-013 done  output  1  one-cycle pulse on normal completion, registered.

Function
REQ-014 FSM states SHALL be IDLE, SEND and GAP; the encoding is free, and unused codes SHALL return to IDLE.
REQ-015 In IDLE: w=0, valid=0, busy=0, and done=0 except for the completion pulse.
REQ-016 start=1 in IDLE with 1<=len<=MAX_LEN and stop=0 SHALL, at that edge, latch pattern/len/reps, enter SEND and drive w=pattern[len-1], valid=1, busy=1 (zero-cycle latency from the sampling edge).
REQ-017 start with len=0 or len>MAX_LEN SHALL be ignored: the block stays in IDLE and done is not pulsed.
REQ-018 start while busy SHALL be ignored; pattern/len/reps changes while busy SHALL have no effect.
REQ-019 In SEND, each edge SHALL advance one bit, MSB-first (pattern[len-1] down to pattern[0]), with valid=1 for exactly len consecutive cycles per repetition.
REQ-020 After bit 0 of a repetition that is not the last: if GAP>0, enter GAP for exactly GAP cycles (w=0, valid=0, busy=1), then return to SEND at bit len-1; if GAP=0, bit len-1 of the next repetition SHALL follow bit 0 with no bubble.
REQ-021 Repetition counter SHALL count completed repetitions; when reps=N (N>0), exactly N repetitions are sent.
REQ-022 After bit 0 of the last repetition, the next edge SHALL enter IDLE with busy=0, valid=0, w=0 and done=1 for exactly one cycle.
REQ-023 When reps=0, the block SHALL repeat indefinitely and SHALL never assert done.
REQ-024 stop=1 in SEND or GAP SHALL, at that edge, force IDLE with w=0, valid=0, busy=0 and no done pulse.
REQ-025 When start=1 and stop=1 in the same IDLE cycle, stop SHALL win and the block SHALL remain in IDLE.
REQ-026 A start in the cycle in which done=1 (state IDLE) SHALL be accepted per REQ-016, and done and the first bit may coincide.
REQ-027 The bit index SHALL never under-flow or wrap: after index 0 it reloads to len-1 or the block leaves SEND.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, w=0, valid=0, busy=0, done=0, and clear the bit index, repetition counter and gap counter, including mid-transmission.
REQ-029 After rst is released, the first accepted start SHALL behave per REQ-016 with no residual state.

Verification
REQ-030 MAX_LEN=16, GAP=2; pattern=0x000B, len=4, reps=1, start pulse -> w=1,0,1,1 with valid=1 for 4 cycles, then done=1 for 1 cycle, busy=0.
REQ-031 pattern=0x0006, len=3, reps=2 -> w/valid: 1,1,0 (valid=1); 0,0 (valid=0, GAP); 1,1,0 (valid=1); then done pulse; 8 busy cycles in total.
REQ-032 GAP=0 build; pattern=0x0003, len=2, reps=3 -> six consecutive valid cycles with w=1, then a single done pulse.
REQ-033 reps=0, len=4, pattern=0x0009; stop asserted in cycle 6 -> w=1,0,0,1,(gap),1 then IDLE on the stop edge, done never asserted.
REQ-034 start with len=0, and start+stop together -> busy, valid and done stay 0.
REQ-035 rst asserted asynchronously at bit 2 of a len=8 transfer -> all outputs 0 immediately; a subsequent start sends the full new pattern correctly.
